// File: rtl/input_debounce8.sv
// input_debounce8: per-bit two-flop synchronizer plus tick-sampled stability counters.
// A bit of X flips only after its synchronized input disagrees with it for STABLE_TICKS ticks.
module input_debounce8 #(
  parameter int TICK_DIV = 50000,
  parameter int STABLE_TICKS = 10,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] SW,
  output logic [7:0] X,
  output logic       CHG,
  output logic       BUSY
);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_TICKS - 1);
  logic [7:0] s1, s2, acc, busy_v;
  logic [15:0] pre;
  logic tick;
  logic [7:0][7:0] c;
  assign tick = pre == TICK_LAST;
  assign BUSY = |busy_v;
  genvar i;
  for (i = 0; i < 8; i++) begin : g_ch
    assign acc[i] = (s2[i] != X[i]) && tick && (c[i] == CNT_LAST);
    assign busy_v[i] = |c[i];
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      s1 <= '0;
      s2 <= '0;
      pre <= '0;
      X <= INIT_VAL;
      CHG <= 1'b0;
    end else begin
      s1 <= SW;
      s2 <= s1;
      pre <= tick ? '0 : pre + 16'd1;
      X <= (X & ~acc) | (s2 & acc);
      CHG <= |acc;
    end
  // A matching input (or an acceptance) always restarts the count; otherwise it advances only on ticks.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) c <= '0;
    else for (int k = 0; k < 8; k++) c[k] <= (s2[k] == X[k] || acc[k]) ? '0 : tick ? c[k] + 8'd1 : c[k];
endmodule
